// File: rtl/vx_tl_core_mem_adapter_if.sv
// Bus bundles for the Vortex core/TileLink memory adapter.
// The core side carries the cache request/response pairs; the TL side carries the A/D channels.

interface vx_core_mem_if #(
   parameter int NUM_LANES   = 4,
   parameter int WORD_ADDR_W = 30,
   parameter int DTAG_W      = 8,
   parameter int ITAG_W      = 8
);
   logic                                   icache_req_valid;
   logic [WORD_ADDR_W-1:0]                 icache_req_addr;
   logic [ITAG_W-1:0]                      icache_req_tag;
   logic                                   icache_req_ready;
   logic                                   icache_rsp_valid;
   logic [31:0]                            icache_rsp_data;
   logic [ITAG_W-1:0]                      icache_rsp_tag;
   logic                                   icache_rsp_ready;

   logic [NUM_LANES-1:0]                   dcache_req_valid;
   logic [NUM_LANES-1:0]                   dcache_req_rw;
   logic [NUM_LANES-1:0][3:0]              dcache_req_byteen;
   logic [NUM_LANES-1:0][WORD_ADDR_W-1:0]  dcache_req_addr;
   logic [NUM_LANES-1:0][31:0]             dcache_req_data;
   logic [DTAG_W-1:0]                      dcache_req_tag;
   logic [NUM_LANES-1:0]                   dcache_req_ready;
   logic                                   dcache_rsp_valid;
   logic [NUM_LANES-1:0]                   dcache_rsp_tmask;
   logic [NUM_LANES-1:0][31:0]             dcache_rsp_data;
   logic [DTAG_W-1:0]                      dcache_rsp_tag;
   logic                                   dcache_rsp_ready;

   // The core is the master of its cache interfaces.
   modport master (
      output icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
      input  icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
      output dcache_req_valid, dcache_req_rw, dcache_req_byteen, dcache_req_addr,
      output dcache_req_data, dcache_req_tag, dcache_rsp_ready,
      input  dcache_req_ready, dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag
   );

   modport slave (
      input  icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
      output icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
      input  dcache_req_valid, dcache_req_rw, dcache_req_byteen, dcache_req_addr,
      input  dcache_req_data, dcache_req_tag, dcache_rsp_ready,
      output dcache_req_ready, dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag
   );
endinterface

interface vx_tl_mem_if #(
   parameter int NUM_LANES = 4,
   parameter int SRC_W     = 10
);
   logic                            imem_a_valid;
   logic [2:0]                      imem_a_opcode;
   logic [3:0]                      imem_a_size;
   logic [SRC_W-1:0]                imem_a_source;
   logic [31:0]                     imem_a_address;
   logic [3:0]                      imem_a_mask;
   logic [31:0]                     imem_a_data;
   logic                            imem_a_ready;
   logic                            imem_d_valid;
   logic [2:0]                      imem_d_opcode;
   logic [3:0]                      imem_d_size;
   logic [SRC_W-1:0]                imem_d_source;
   logic [31:0]                     imem_d_data;
   logic                            imem_d_ready;

   logic [NUM_LANES-1:0]            dmem_a_valid;
   logic [NUM_LANES-1:0][2:0]       dmem_a_opcode;
   logic [NUM_LANES-1:0][3:0]       dmem_a_size;
   logic [NUM_LANES-1:0][SRC_W-1:0] dmem_a_source;
   logic [NUM_LANES-1:0][31:0]      dmem_a_address;
   logic [NUM_LANES-1:0][3:0]       dmem_a_mask;
   logic [NUM_LANES-1:0][31:0]      dmem_a_data;
   logic [NUM_LANES-1:0]            dmem_a_ready;
   logic [NUM_LANES-1:0]            dmem_d_valid;
   logic [NUM_LANES-1:0][2:0]       dmem_d_opcode;
   logic [NUM_LANES-1:0][3:0]       dmem_d_size;
   logic [NUM_LANES-1:0][SRC_W-1:0] dmem_d_source;
   logic [NUM_LANES-1:0][31:0]      dmem_d_data;
   logic [NUM_LANES-1:0]            dmem_d_ready;

   // The adapter masters the A channels and consumes the D channels.
   modport master (
      output imem_a_valid, imem_a_opcode, imem_a_size, imem_a_source, imem_a_address,
      output imem_a_mask, imem_a_data, imem_d_ready,
      input  imem_a_ready, imem_d_valid, imem_d_opcode, imem_d_size, imem_d_source, imem_d_data,
      output dmem_a_valid, dmem_a_opcode, dmem_a_size, dmem_a_source, dmem_a_address,
      output dmem_a_mask, dmem_a_data, dmem_d_ready,
      input  dmem_a_ready, dmem_d_valid, dmem_d_opcode, dmem_d_size, dmem_d_source, dmem_d_data
   );

   modport slave (
      input  imem_a_valid, imem_a_opcode, imem_a_size, imem_a_source, imem_a_address,
      input  imem_a_mask, imem_a_data, imem_d_ready,
      output imem_a_ready, imem_d_valid, imem_d_opcode, imem_d_size, imem_d_source, imem_d_data,
      input  dmem_a_valid, dmem_a_opcode, dmem_a_size, dmem_a_source, dmem_a_address,
      input  dmem_a_mask, dmem_a_data, dmem_d_ready,
      output dmem_a_ready, dmem_d_valid, dmem_d_opcode, dmem_d_size, dmem_d_source, dmem_d_data
   );
endinterface

// File: rtl/vx_tl_core_mem_adapter.sv
// Bridges Vortex icache/dcache ports onto TileLink-UL A/D channels and
// stretches an msip rising edge into a fixed-length core reset pulse.

module vx_tl_core_mem_adapter #(
   parameter int NUM_LANES       = 4,
   parameter int WORD_ADDR_W     = 30,
   parameter int DTAG_W          = 8,
   parameter int ITAG_W          = 8,
   parameter int SRC_W           = 10,
   parameter int INTR_RST_CYCLES = 6
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          interrupts_msip,
   input  logic          busy,
   output logic          core_reset,
   output logic          cease,
   output logic          wfi,
   vx_core_mem_if.slave  core,
   vx_tl_mem_if.master   tl
);

   localparam logic [2:0] TL_PUT_FULL    = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] TL_GET         = 3'd4;
   localparam logic [2:0] TL_ACCESS_ACK  = 3'd0;
   localparam logic [3:0] RST_RELOAD     = 4'(INTR_RST_CYCLES);

   logic                 msip_q;
   logic [3:0]           cnt_q;
   logic [3:0]           cnt_d;
   logic [NUM_LANES-1:0] hit;
   logic [DTAG_W-1:0]    rspTag;
   logic                 unusedBits;

   // A fresh msip edge always reloads, even mid-pulse; otherwise count down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!msip_q && interrupts_msip) begin
         cnt_d = RST_RELOAD;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         msip_q <= 1'b0;
         cnt_q  <= 4'd0;
      end else begin
         msip_q <= interrupts_msip;
         cnt_q  <= cnt_d;
      end
   end

   assign core_reset = !reset_n || (cnt_q != 4'd0);
   assign cease      = ~busy;
   assign wfi        = 1'b0;

   assign tl.imem_a_valid      = core.icache_req_valid;
   assign core.icache_req_ready = tl.imem_a_ready;
   assign tl.imem_a_opcode     = TL_GET;
   assign tl.imem_a_size       = 4'd2;
   assign tl.imem_a_source     = SRC_W'(core.icache_req_tag);
   assign tl.imem_a_address    = {core.icache_req_addr, 2'b00};
   assign tl.imem_a_mask       = 4'hF;
   assign tl.imem_a_data       = 32'd0;

   assign core.icache_rsp_valid = tl.imem_d_valid;
   assign core.icache_rsp_data  = tl.imem_d_data;
   assign core.icache_rsp_tag   = tl.imem_d_source[ITAG_W-1:0];
   assign tl.imem_d_ready       = core.icache_rsp_ready;

   for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
      assign tl.dmem_a_valid[i]     = core.dcache_req_valid[i];
      assign core.dcache_req_ready[i] = tl.dmem_a_ready[i];
      assign tl.dmem_a_address[i]   = {core.dcache_req_addr[i], 2'b00};
      assign tl.dmem_a_source[i]    = SRC_W'(core.dcache_req_tag);
      assign tl.dmem_a_data[i]      = core.dcache_req_data[i];
      assign tl.dmem_a_mask[i]      = core.dcache_req_byteen[i];
      assign tl.dmem_a_size[i]      = 4'd2;
      assign tl.dmem_a_opcode[i]    = !core.dcache_req_rw[i]            ? TL_GET :
                                      (core.dcache_req_byteen[i] == 4'hF) ? TL_PUT_FULL :
                                                                            TL_PUT_PARTIAL;
      // Write acks carry no data, so they are hidden from the core but still drained.
      assign hit[i]                 = tl.dmem_d_valid[i] && (tl.dmem_d_opcode[i] != TL_ACCESS_ACK);
      assign tl.dmem_d_ready[i]     = core.dcache_rsp_ready;
   end

   // Highest-index valid lane wins the tag, acks included.
   always_comb begin
      rspTag = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (tl.dmem_d_valid[i]) begin
            rspTag = tl.dmem_d_source[i][DTAG_W-1:0];
         end
      end
   end

   assign core.dcache_rsp_valid = |hit;
   assign core.dcache_rsp_tmask = hit;
   assign core.dcache_rsp_data  = tl.dmem_d_data;
   assign core.dcache_rsp_tag   = rspTag;

   assign unusedBits = ^{tl.imem_d_opcode, tl.imem_d_size, tl.imem_d_source,
                         tl.dmem_d_size, tl.dmem_d_source};

endmodule

// File: tb/tb_vx_tl_core_mem_adapter.sv
// Directed bench for vx_tl_core_mem_adapter: vector table for the dcache
// datapath plus hand-written sequences for reset pulse and icache path.

module tb_vx_tl_core_mem_adapter;

   logic clock;
   logic reset_n;
   logic interrupts_msip;
   logic busy;
   logic core_reset;
   logic cease;
   logic wfi;

   int vecCount  = 0;
   int failCount = 0;

   vx_core_mem_if coreIf ();
   vx_tl_mem_if   tlIf ();

   vx_tl_core_mem_adapter dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .interrupts_msip (interrupts_msip),
      .busy            (busy),
      .core_reset      (core_reset),
      .cease           (cease),
      .wfi             (wfi),
      .core            (coreIf),
      .tl              (tlIf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]        reqValid;
      logic [3:0]        rw;
      logic [3:0][3:0]   byteen;
      logic [3:0][29:0]  addr;
      logic [3:0][31:0]  wdata;
      logic [7:0]        tag;
      logic [3:0]        aReady;
      logic [3:0]        dValid;
      logic [3:0][2:0]   dOpcode;
      logic [3:0][9:0]   dSource;
      logic [3:0][31:0]  rdata;
      logic              rspReady;
      logic [3:0][2:0]   expOpcode;
      logic              expRspValid;
      logic [3:0]        expTmask;
      logic [7:0]        expTag;
   } vec_t;

   vec_t vec [4];

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      vecCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one dcache table entry onto the core and TL sides.
   task automatic applyStimulus(input vec_t v);
      coreIf.dcache_req_valid  = v.reqValid;
      coreIf.dcache_req_rw     = v.rw;
      coreIf.dcache_req_byteen = v.byteen;
      coreIf.dcache_req_addr   = v.addr;
      coreIf.dcache_req_data   = v.wdata;
      coreIf.dcache_req_tag    = v.tag;
      coreIf.dcache_rsp_ready  = v.rspReady;
      tlIf.dmem_a_ready        = v.aReady;
      tlIf.dmem_d_valid        = v.dValid;
      tlIf.dmem_d_opcode       = v.dOpcode;
      tlIf.dmem_d_source       = v.dSource;
      tlIf.dmem_d_data         = v.rdata;
      tlIf.dmem_d_size         = {4{4'd2}};
   endtask

   initial begin
      logic [3:0][31:0] expAddr;
      logic [3:0][9:0]  expSrc;

      // Lanes listed MSB first: lane3, lane2, lane1, lane0.
      vec[0].reqValid = 4'b0111; vec[0].rw = 4'b0110; vec[0].byteen = {4'h0, 4'h3, 4'hF, 4'hF};
      vec[0].tag = 8'h3C; vec[0].aReady = 4'b0101; vec[0].rspReady = 1'b1;
      vec[0].dValid = 4'b1011; vec[0].dOpcode = {3'd0, 3'd1, 3'd1, 3'd1};
      vec[0].dSource = {10'd7, 10'd0, 10'd6, 10'd5};
      vec[0].expOpcode = {3'd4, 3'd1, 3'd0, 3'd4}; vec[0].expRspValid = 1'b1;
      vec[0].expTmask = 4'b0011; vec[0].expTag = 8'h07;

      vec[1].reqValid = 4'b1010; vec[1].rw = 4'b1111; vec[1].byteen = {4'hF, 4'h0, 4'hE, 4'hF};
      vec[1].tag = 8'hA5; vec[1].aReady = 4'b1010; vec[1].rspReady = 1'b0;
      vec[1].dValid = 4'b0110; vec[1].dOpcode = {3'd0, 3'd1, 3'd1, 3'd0};
      vec[1].dSource = {10'd0, 10'h2FF, 10'd3, 10'd0};
      vec[1].expOpcode = {3'd0, 3'd1, 3'd1, 3'd0}; vec[1].expRspValid = 1'b1;
      vec[1].expTmask = 4'b0110; vec[1].expTag = 8'hFF;

      vec[2].reqValid = 4'b0000; vec[2].rw = 4'b0000; vec[2].byteen = {4'h3, 4'hF, 4'h0, 4'h5};
      vec[2].tag = 8'hFF; vec[2].aReady = 4'b1111; vec[2].rspReady = 1'b1;
      vec[2].dValid = 4'b1001; vec[2].dOpcode = {3'd0, 3'd0, 3'd0, 3'd0};
      vec[2].dSource = {10'h3C5, 10'd0, 10'd0, 10'h011};
      vec[2].expOpcode = {3'd4, 3'd4, 3'd4, 3'd4}; vec[2].expRspValid = 1'b0;
      vec[2].expTmask = 4'b0000; vec[2].expTag = 8'hC5;

      vec[3].reqValid = 4'b1111; vec[3].rw = 4'b1111; vec[3].byteen = {4'h7, 4'h8, 4'hF, 4'h1};
      vec[3].tag = 8'h01; vec[3].aReady = 4'b0000; vec[3].rspReady = 1'b1;
      vec[3].dValid = 4'b0000; vec[3].dOpcode = {3'd1, 3'd1, 3'd1, 3'd1};
      vec[3].dSource = {10'h055, 10'h066, 10'h077, 10'h088};
      vec[3].expOpcode = {3'd1, 3'd1, 3'd0, 3'd1}; vec[3].expRspValid = 1'b0;
      vec[3].expTmask = 4'b0000; vec[3].expTag = 8'h00;

      for (int v = 0; v < 4; v++) begin
         for (int l = 0; l < 4; l++) begin
            vec[v].addr[l]  = 30'(32'h0123_4567 * (v + 1) + l * 32'h0011_1111);
            vec[v].wdata[l] = 32'hA000_0000 + 32'(v * 16 + l);
            vec[v].rdata[l] = 32'h5000_0000 + 32'(v * 256 + l * 17);
         end
      end

      reset_n = 1'b0;
      interrupts_msip = 1'b0;
      busy = 1'b1;
      coreIf.icache_req_valid = 1'b0;
      coreIf.icache_req_addr  = '0;
      coreIf.icache_req_tag   = '0;
      coreIf.icache_rsp_ready = 1'b0;
      tlIf.imem_a_ready  = 1'b0;
      tlIf.imem_d_valid  = 1'b0;
      tlIf.imem_d_opcode = 3'd1;
      tlIf.imem_d_size   = 4'd2;
      tlIf.imem_d_source = '0;
      tlIf.imem_d_data   = '0;
      applyStimulus(vec[3]);

      #2;
      checkOutput("core_reset_in_reset", 128'(core_reset), 128'd1);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("core_reset_after_release", 128'(core_reset), 128'd0);
      checkOutput("cease_busy", 128'(cease), 128'd0);
      checkOutput("wfi", 128'(wfi), 128'd0);
      busy = 1'b0;
      #1;
      checkOutput("cease_idle", 128'(cease), 128'd1);

      // msip rise: exactly six asserted cycles, no retrigger while held high.
      @(negedge clock);
      interrupts_msip = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         checkOutput($sformatf("pulse_cycle%0d", k + 1), 128'(core_reset), 128'd1);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         checkOutput($sformatf("pulse_done%0d", k), 128'(core_reset), 128'd0);
      end

      // A second edge mid-pulse reloads the full count.
      @(negedge clock); interrupts_msip = 1'b0;
      @(negedge clock); interrupts_msip = 1'b1;
      @(posedge clock); #1;
      checkOutput("reload_first", 128'(core_reset), 128'd1);
      @(negedge clock); interrupts_msip = 1'b0;
      @(posedge clock); #1;
      checkOutput("reload_second", 128'(core_reset), 128'd1);
      @(negedge clock); interrupts_msip = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         checkOutput($sformatf("reload_cycle%0d", k + 1), 128'(core_reset), 128'd1);
      end
      @(posedge clock); #1;
      checkOutput("reload_done", 128'(core_reset), 128'd0);

      // Asynchronous reset mid-pulse clears the counter without a clock edge.
      @(negedge clock); interrupts_msip = 1'b0;
      @(negedge clock); interrupts_msip = 1'b1;
      @(posedge clock); #1;
      checkOutput("async_pre", 128'(core_reset), 128'd1);
      #1 reset_n = 1'b0; interrupts_msip = 1'b0;
      #1 reset_n = 1'b1;
      #1 checkOutput("async_cleared", 128'(core_reset), 128'd0);
      @(posedge clock); #1;
      checkOutput("async_stays_low", 128'(core_reset), 128'd0);

      // Icache request/response passthrough.
      @(negedge clock);
      coreIf.icache_req_valid = 1'b1;
      coreIf.icache_req_addr  = 30'h0000_0100;
      coreIf.icache_req_tag   = 8'h2A;
      coreIf.icache_rsp_ready = 1'b0;
      tlIf.imem_a_ready  = 1'b1;
      tlIf.imem_d_valid  = 1'b1;
      tlIf.imem_d_source = 10'h12A;
      tlIf.imem_d_data   = 32'hDEAD_BEEF;
      #1;
      checkOutput("imem_a_valid", 128'(tlIf.imem_a_valid), 128'd1);
      checkOutput("imem_a_address", 128'(tlIf.imem_a_address), 128'h400);
      checkOutput("imem_a_source", 128'(tlIf.imem_a_source), 128'h02A);
      checkOutput("imem_a_opcode", 128'(tlIf.imem_a_opcode), 128'd4);
      checkOutput("imem_a_size", 128'(tlIf.imem_a_size), 128'd2);
      checkOutput("imem_a_mask", 128'(tlIf.imem_a_mask), 128'hF);
      checkOutput("imem_a_data", 128'(tlIf.imem_a_data), 128'd0);
      checkOutput("icache_req_ready_hi", 128'(coreIf.icache_req_ready), 128'd1);
      checkOutput("icache_rsp_valid_hi", 128'(coreIf.icache_rsp_valid), 128'd1);
      checkOutput("icache_rsp_tag", 128'(coreIf.icache_rsp_tag), 128'h2A);
      checkOutput("icache_rsp_data", 128'(coreIf.icache_rsp_data), 128'hDEAD_BEEF);
      checkOutput("imem_d_ready_lo", 128'(tlIf.imem_d_ready), 128'd0);
      @(negedge clock);
      coreIf.icache_req_valid = 1'b0;
      coreIf.icache_rsp_ready = 1'b1;
      tlIf.imem_a_ready = 1'b0;
      tlIf.imem_d_valid = 1'b0;
      #1;
      checkOutput("imem_a_valid_lo", 128'(tlIf.imem_a_valid), 128'd0);
      checkOutput("icache_req_ready_lo", 128'(coreIf.icache_req_ready), 128'd0);
      checkOutput("icache_rsp_valid_lo", 128'(coreIf.icache_rsp_valid), 128'd0);
      checkOutput("imem_d_ready_hi", 128'(tlIf.imem_d_ready), 128'd1);

      // Dcache table.
      for (int v = 0; v < 4; v++) begin
         @(negedge clock);
         applyStimulus(vec[v]);
         #1;
         for (int l = 0; l < 4; l++) begin
            expAddr[l] = {vec[v].addr[l], 2'b00};
            expSrc[l]  = {2'b00, vec[v].tag};
         end
         checkOutput($sformatf("v%0d_a_valid", v), 128'(tlIf.dmem_a_valid), 128'(vec[v].reqValid));
         checkOutput($sformatf("v%0d_a_opcode", v), 128'(tlIf.dmem_a_opcode), 128'(vec[v].expOpcode));
         checkOutput($sformatf("v%0d_a_mask", v), 128'(tlIf.dmem_a_mask), 128'(vec[v].byteen));
         checkOutput($sformatf("v%0d_a_size", v), 128'(tlIf.dmem_a_size), 128'h2222);
         checkOutput($sformatf("v%0d_a_address", v), 128'(tlIf.dmem_a_address), 128'(expAddr));
         checkOutput($sformatf("v%0d_a_source", v), 128'(tlIf.dmem_a_source), 128'(expSrc));
         checkOutput($sformatf("v%0d_a_data", v), 128'(tlIf.dmem_a_data), 128'(vec[v].wdata));
         checkOutput($sformatf("v%0d_req_ready", v), 128'(coreIf.dcache_req_ready), 128'(vec[v].aReady));
         checkOutput($sformatf("v%0d_rsp_valid", v), 128'(coreIf.dcache_rsp_valid), 128'(vec[v].expRspValid));
         checkOutput($sformatf("v%0d_rsp_tmask", v), 128'(coreIf.dcache_rsp_tmask), 128'(vec[v].expTmask));
         checkOutput($sformatf("v%0d_rsp_tag", v), 128'(coreIf.dcache_rsp_tag), 128'(vec[v].expTag));
         checkOutput($sformatf("v%0d_rsp_data", v), 128'(coreIf.dcache_rsp_data), 128'(vec[v].rdata));
         checkOutput($sformatf("v%0d_d_ready", v), 128'(tlIf.dmem_d_ready), 128'({4{vec[v].rspReady}}));
      end

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
